// File: rtl/fp_addsub_arbiter.sv
// fp_addsub_arbiter: round-robin scheduler sharing one pipelined FP16 add/sub
// datapath among NUM requesters. A {valid, tag} pipeline of LATENCY stages
// runs beside the datapath so each result is returned to the requester that
// issued it. There is no result buffering; requesters always sink results.
//
// Optional feature: define FPADD_ARB_STATS_EN to add a saturating 16-bit
// transfer counter on output op_count.
module fp_addsub_arbiter #(
    parameter int NUM     = 4,
    parameter int DWIDTH  = 16,
    parameter int LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  en,
    input  logic [NUM-1:0]        req_valid,
    output logic [NUM-1:0]        req_ready,
    input  logic [NUM*DWIDTH-1:0] req_a,
    input  logic [NUM*DWIDTH-1:0] req_b,
    input  logic [NUM-1:0]        req_op,
    output logic                  fp_valid,
    output logic [DWIDTH-1:0]     fp_a,
    output logic [DWIDTH-1:0]     fp_b,
    output logic                  fp_op,
    input  logic [DWIDTH-1:0]     fp_result,
    output logic [NUM-1:0]        res_valid,
    output logic [DWIDTH-1:0]     res_data,
`ifdef FPADD_ARB_STATS_EN
    output logic [15:0]           op_count,
`endif
    output logic                  busy
);

    localparam int PW = (NUM > 1) ? $clog2(NUM) : 1;

    logic [PW-1:0]               ptr_q, ptr_d;
    logic                        fp_valid_q, fp_valid_d;
    logic [DWIDTH-1:0]           fp_a_q, fp_a_d;
    logic [DWIDTH-1:0]           fp_b_q, fp_b_d;
    logic                        fp_op_q, fp_op_d;
    logic [PW-1:0]               issue_idx_q, issue_idx_d;
    logic [LATENCY-1:0]          tag_vld_q, tag_vld_d;
    logic [LATENCY-1:0][PW-1:0]  tag_q, tag_d;
    logic [NUM-1:0]              res_valid_q, res_valid_d;
    logic [DWIDTH-1:0]           res_data_q, res_data_d;

    logic                        grant_vld;
    logic [PW-1:0]               grant_idx;

    // Round-robin search starting at ptr, wrapping; grant only while enabled.
    always_comb begin
        int cand;
        req_ready = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int k = 0; k < NUM; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NUM) cand = cand - NUM;
            if (!grant_vld && en && req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = PW'(cand);
            end
        end
        if (grant_vld) req_ready[grant_idx] = 1'b1;
    end

    // Issue stage, tag pipeline and result return next-state logic.
    always_comb begin
        fp_valid_d  = grant_vld;
        fp_a_d      = fp_a_q;
        fp_b_d      = fp_b_q;
        fp_op_d     = fp_op_q;
        issue_idx_d = issue_idx_q;
        ptr_d       = ptr_q;
        if (grant_vld) begin
            fp_a_d      = req_a[grant_idx*DWIDTH +: DWIDTH];
            fp_b_d      = req_b[grant_idx*DWIDTH +: DWIDTH];
            fp_op_d     = req_op[grant_idx];
            issue_idx_d = grant_idx;
            ptr_d       = (grant_idx == PW'(NUM - 1)) ? '0 : grant_idx + 1'b1;
        end

        tag_vld_d    = tag_vld_q;
        tag_d        = tag_q;
        tag_vld_d[0] = fp_valid_q;
        tag_d[0]     = issue_idx_q;
        for (int s = 1; s < LATENCY; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_d[s]     = tag_q[s-1];
        end

        res_valid_d = '0;
        res_data_d  = res_data_q;
        if (tag_vld_q[LATENCY-1]) begin
            res_valid_d[tag_q[LATENCY-1]] = 1'b1;
            res_data_d                    = fp_result;
        end
    end

    // State registers; synchronous reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ptr_q       <= '0;
            fp_valid_q  <= 1'b0;
            fp_a_q      <= '0;
            fp_b_q      <= '0;
            fp_op_q     <= 1'b0;
            issue_idx_q <= '0;
            tag_vld_q   <= '0;
            tag_q       <= '0;
            res_valid_q <= '0;
            res_data_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            fp_valid_q  <= fp_valid_d;
            fp_a_q      <= fp_a_d;
            fp_b_q      <= fp_b_d;
            fp_op_q     <= fp_op_d;
            issue_idx_q <= issue_idx_d;
            tag_vld_q   <= tag_vld_d;
            tag_q       <= tag_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

`ifdef FPADD_ARB_STATS_EN
    logic [15:0] op_count_q, op_count_d;

    // Saturating count of accepted operations.
    always_comb begin
        op_count_d = op_count_q;
        if (grant_vld && (op_count_q != 16'hFFFF)) op_count_d = op_count_q + 16'd1;
    end

    // Counter register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!resetn) op_count_q <= '0;
        else         op_count_q <= op_count_d;
    end

    assign op_count = op_count_q;
`endif

    assign fp_valid  = fp_valid_q;
    assign fp_a      = fp_a_q;
    assign fp_b      = fp_b_q;
    assign fp_op     = fp_op_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign busy      = fp_valid_q | (|tag_vld_q) | (|res_valid_q);

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Testbench for fp_addsub_arbiter: random and directed stimulus, a reference
// arbitration model, a behavioural FP16 datapath, and a scoreboard monitor.
module tb_fp_addsub_arbiter;
    localparam int NUM = 4;
    localparam int DW  = 16;
    localparam int LAT = 3;

    logic              clk = 1'b0;
    logic              resetn;
    logic              en;
    logic [NUM-1:0]    req_valid;
    logic [NUM-1:0]    req_ready;
    logic [NUM*DW-1:0] req_a;
    logic [NUM*DW-1:0] req_b;
    logic [NUM-1:0]    req_op;
    logic              fp_valid;
    logic [DW-1:0]     fp_a;
    logic [DW-1:0]     fp_b;
    logic              fp_op;
    logic [DW-1:0]     fp_result;
    logic [NUM-1:0]    res_valid;
    logic [DW-1:0]     res_data;
    logic              busy;
`ifdef FPADD_ARB_STATS_EN
    logic [15:0]       op_count;
`endif

    always #5 clk = ~clk;

    fp_addsub_arbiter #(.NUM(NUM), .DWIDTH(DW), .LATENCY(LAT)) dut (
        .clk(clk), .resetn(resetn), .en(en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .fp_valid(fp_valid), .fp_a(fp_a), .fp_b(fp_b), .fp_op(fp_op),
        .fp_result(fp_result),
        .res_valid(res_valid), .res_data(res_data),
`ifdef FPADD_ARB_STATS_EN
        .op_count(op_count),
`endif
        .busy(busy)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // FP16 <-> real helpers for the behavioural datapath.
    function automatic real f2r(input logic [15:0] h);
        real m;
        int  e;
        if (h[14:10] == 5'd0) begin
            m = real'(h[9:0]) / 1024.0;
            e = -14;
        end else begin
            m = 1.0 + real'(h[9:0]) / 1024.0;
            e = int'(h[14:10]) - 15;
        end
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return h[15] ? -m : m;
    endfunction

    function automatic logic [15:0] r2f(input real r);
        logic s;
        real  mag;
        int   e;
        int   mant;
        if (r == 0.0) return 16'h0000;
        s   = (r < 0.0);
        mag = s ? -r : r;
        e   = 15;
        while (mag >= 2.0 && e < 40) begin mag = mag / 2.0; e++; end
        while (mag < 1.0 && e > -30) begin mag = mag * 2.0; e--; end
        if (e <= 0)  return {s, 15'd0};
        if (e >= 31) return {s, 5'h1F, 10'd0};
        mant = $rtoi((mag - 1.0) * 1024.0);
        return {s, 5'(e), 10'(mant)};
    endfunction

    function automatic logic [15:0] dp_func(input logic [15:0] a, input logic [15:0] b, input logic op);
        return r2f(op ? (f2r(a) - f2r(b)) : (f2r(a) + f2r(b)));
    endfunction

    function automatic logic [15:0] rand_fp();
        logic [15:0] v;
        v[15]    = 1'($urandom_range(0, 1));
        v[14:10] = 5'($urandom_range(12, 18));
        v[9:0]   = 10'($urandom_range(0, 1023));
        return v;
    endfunction

    // Behavioural datapath: fixed LAT-stage pipeline.
    logic [DW-1:0] dp_pipe [LAT];
    always @(posedge clk) begin
        dp_pipe[0] <= dp_func(fp_a, fp_b, fp_op);
        for (int k = 1; k < LAT; k++) dp_pipe[k] <= dp_pipe[k-1];
    end
    assign fp_result = dp_pipe[LAT-1];

    typedef struct {
        int          tag;
        logic [15:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];

    // Monitor: pops the scoreboard whenever a result is presented or is overdue.
    always @(negedge clk) begin
        exp_t e;
        if (res_valid !== '0) begin
            if (sb.size() == 0) begin
                check("unexpected_res", 32'(res_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("res_tag", 32'(res_valid), 32'(1 << e.tag));
                check("res_data", 32'(res_data), 32'(e.data));
                check("res_cycle", 32'(cyc), 32'(e.due));
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check("res_missing", 32'(res_valid), 32'(1 << e.tag));
        end
    end

    logic [15:0] a_arr [NUM];
    logic [15:0] b_arr [NUM];
    logic        op_arr[NUM];
    int          mptr      = 0;
    logic        force_en  = 1'b0;
    logic [15:0] force_d   = '0;
    int          dut_grant = -1;

    // One clock of stimulus with reference arbitration and issue checks.
    task automatic step(input logic [NUM-1:0] v, input logic e);
        int   g;
        exp_t x;
        req_valid = v;
        en        = e;
        for (int i = 0; i < NUM; i++) begin
            req_a[i*DW +: DW] = a_arr[i];
            req_b[i*DW +: DW] = b_arr[i];
            req_op[i]         = op_arr[i];
        end
        #1;
        g = -1;
        if (e) begin
            for (int k = 0; k < NUM; k++)
                if (g < 0 && v[(mptr + k) % NUM]) g = (mptr + k) % NUM;
        end
        check("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : 32'(1 << g));
        dut_grant = -1;
        for (int i = 0; i < NUM; i++) if (req_ready[i]) dut_grant = i;
        if (g >= 0) begin
            x.tag  = g;
            x.data = force_en ? force_d : dp_func(a_arr[g], b_arr[g], op_arr[g]);
            x.due  = cyc + LAT + 2;
            sb.push_back(x);
            mptr = (g + 1) % NUM;
        end
        @(posedge clk);
        #1;
        check("fp_valid", 32'(fp_valid), 32'(g >= 0));
        if (g >= 0) begin
            check("fp_a", 32'(fp_a), 32'(a_arr[g]));
            check("fp_b", 32'(fp_b), 32'(b_arr[g]));
            check("fp_op", 32'(fp_op), 32'(op_arr[g]));
        end
        check("busy", 32'(busy), 32'((g >= 0) || (sb.size() > 0)));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, 1'b1);
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        req_valid = '0;
        en        = 1'b0;
        @(posedge clk);
        sb.delete();
        mptr = 0;
        #1;
        check("rst_fp_valid", 32'(fp_valid), 32'd0);
        check("rst_fp_a", 32'(fp_a), 32'd0);
        check("rst_fp_b", 32'(fp_b), 32'd0);
        check("rst_fp_op", 32'(fp_op), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
`ifdef FPADD_ARB_STATS_EN
        check("rst_op_count", 32'(op_count), 32'd0);
`endif
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NUM; i++) begin
            a_arr[i]  = rand_fp();
            b_arr[i]  = rand_fp();
            op_arr[i] = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        resetn    = 1'b0;
        en        = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        for (int i = 0; i < NUM; i++) begin
            a_arr[i] = '0; b_arr[i] = '0; op_arr[i] = 1'b0;
        end
        @(negedge clk);
        do_reset();

        // Directed add on requester 2: 1.0 + 2.0 = 3.0.
        a_arr[2] = 16'h3C00; b_arr[2] = 16'h4000; op_arr[2] = 1'b0;
        force_en = 1'b1; force_d = 16'h4200;
        step(4'b0100, 1'b1);
        force_en = 1'b0;
        idle(6);

        // Directed subtract on requester 0: 3.0 - 1.0 = 2.0.
        a_arr[0] = 16'h4200; b_arr[0] = 16'h3C00; op_arr[0] = 1'b1;
        force_en = 1'b1; force_d = 16'h4000;
        step(4'b0001, 1'b1);
        force_en = 1'b0;
        idle(6);

        // All requesters valid from ptr=0: strict rotation, back-to-back results.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            rand_ops();
            step(4'b1111, 1'b1);
            check("rr_order", 32'(dut_grant), 32'(k % NUM));
        end
        idle(6);

        // Enable low holds off grants; raising it resumes at ptr.
        rand_ops();
        step(4'b0001, 1'b1);
        for (int k = 0; k < 3; k++) step(4'b1111, 1'b0);
        step(4'b1111, 1'b1);
        check("en_resume", 32'(dut_grant), 32'd1);
        idle(6);

        // Single requester held valid is granted every cycle.
        for (int k = 0; k < 5; k++) begin
            rand_ops();
            step(4'b0010, 1'b1);
            check("single_grant", 32'(dut_grant), 32'd1);
        end
        idle(6);

        // Reset while three operations are in flight: none may return.
        for (int k = 0; k < 3; k++) begin
            rand_ops();
            step(4'b1111, 1'b1);
        end
        step('0, 1'b1);
        do_reset();
        idle(8);

        // Random traffic with occasional enable drops.
        for (int k = 0; k < 400; k++) begin
            rand_ops();
            step(NUM'($urandom_range(0, (1 << NUM) - 1)), ($urandom_range(0, 7) != 0));
        end
        idle(8);

`ifdef FPADD_ARB_STATS_EN
        do_reset();
        for (int k = 0; k < 70000; k++) step(4'b0001, 1'b1);
        check("op_count_sat", 32'(op_count), 32'hFFFF);
        for (int k = 0; k < 5; k++) step(4'b0011, 1'b1);
        check("op_count_hold", 32'(op_count), 32'hFFFF);
        idle(8);
`endif

        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fp_addsub_arbiter.md
# fp_addsub_arbiter

Round-robin scheduler that shares one pipelined FP16 add/sub execution datapath among `NUM` requesters in the attention layer, such as the softmax sum and the score-accumulate lanes. It accepts one operation per cycle from the winning requester, drives the datapath operand registers, and carries a requester tag alongside the datapath pipeline. It returns each result to its originator with a one-hot valid. It has no internal result buffering; requesters must always sink results.

## Interface
- `NUM`, 4: number of requesters (2..8).
- `DWIDTH`, 16: operand/result width (1 sign, 5 exponent, 10 mantissa).
- `LATENCY`, 3: cycles from `fp_valid` high with operands to `fp_result` valid (datapath pipeline depth, ≥1).
- `clk` input 1: clock; all logic on the rising edge.
- `resetn` input 1: synchronous, active-low reset.
- `en` input 1: when low, no new grants; in-flight operations still drain.
- `req_valid` input NUM: per-requester operation request.
- `req_ready` output NUM: one-hot grant, combinational from `req_valid`, `en` and the priority pointer.
- `req_a` input NUM*DWIDTH: operand A; requester i occupies bits [i*DWIDTH +: DWIDTH].
- `req_b` input NUM*DWIDTH: operand B, packed the same way.
- `req_op` input NUM: 0 = add, 1 = subtract (A−B).
- `fp_valid` output 1: operands presented to the datapath this cycle.
- `fp_a`, `fp_b` output DWIDTH: registered operands to the datapath.
- `fp_op` output 1: registered OpMode to the datapath.
- `fp_result` input DWIDTH: datapath result, valid LATENCY cycles after its `fp_valid`.
- `res_valid` output NUM: one-hot result strobe.
- `res_data` output DWIDTH: registered result.
- `busy` output 1: high while any operation is in flight.

## Operation
- Priority pointer `ptr` (log2 NUM bits) starts at 0 out of reset.
- Arbitration searches from requester `ptr` upward, with wrap-around. The first `i` with `req_valid[i]` gets `req_ready[i]=1`, but only when `en=1`. At most one bit of `req_ready` is set.
- A transfer happens when `req_valid[i] & req_ready[i]`. On that edge:
  - `fp_a`/`fp_b`/`fp_op` load requester i's operands; `fp_valid` is set to 1.
  - `ptr` becomes `(i+1) mod NUM`.
- With no transfer: `fp_valid` is set to 0, the operand registers hold their values, and `ptr` holds.
- Tag pipeline has LATENCY stages of {valid, tag}. Stage 0 is loaded with {`fp_valid`, issued index} in the cycle `fp_valid` is high.
- When the last tag stage is valid, the next edge registers `res_data <= fp_result` and sets `res_valid` one-hot at the tag. Otherwise `res_valid` is 0 and `res_data` holds.
- `busy` = `fp_valid` OR any tag stage valid OR any `res_valid`.
- `req_valid` may drop before it is granted; a requester that is not granted is not latched.
- `en` falling mid-stream does not cancel in-flight operations; their results still appear.
- Reset mid-operation discards all in-flight operations; no `res_valid` is produced for them.
- Sign, rounding and special cases are entirely the datapath's responsibility; this block never inspects operand bits.

## Timing
- Reset values: `fp_valid`=0, `fp_a`=0, `fp_b`=0, `fp_op`=0, `res_valid`=0, `res_data`=0, `busy`=0, `ptr`=0, all tag-stage valids 0.
- Acceptance edge E:
  - `fp_valid` is high in cycle E+1.
  - `res_valid` is high in cycle E+LATENCY+2, i.e. 5 cycles for LATENCY=3.
- Throughput: one operation per cycle, sustained. Results come back in issue order.
- A single requester holding `req_valid` continuously is granted every cycle when no other requester is valid.
- With all requesters valid, grants rotate 0,1,…,NUM−1,0. No requester waits more than NUM−1 cycles.

## Configuration
- `FPADD_ARB_STATS_EN`:
  - **Defined:** adds output `op_count` (16 bits), reset to 0. It increments on every transfer edge, saturates at 0xFFFF, and clears on reset only.
  - **Undefined:** the port and counter are absent. All other behaviour is identical.

## Test plan
- Single op, LATENCY=3, datapath model: requester 2 issues A=0x3C00, B=0x4000, op=0 at edge E. Required: `fp_valid` high at E+1 with `fp_a`=0x3C00; `res_valid`=4'b0100 with `res_data`=0x4200 at E+5.
- Subtract: requester 0 issues 0x4200 − 0x3C00. Required: `res_data`=0x4000 with `res_valid`=4'b0001.
- All four `req_valid` held high for 8 cycles. Required: grant order 0,1,2,3,0,1,2,3; results are tagged in the same order, one per cycle, back-to-back.
- `en` held low with requests pending. Required: `req_ready`=0 and `fp_valid`=0. Raise `en`; grant starts at the requester pointed to by `ptr`.
- Reset pulse (`resetn`=0 for 1 cycle) issued 2 cycles after 3 issues. Required: no `res_valid` ever appears for them; all outputs are at their reset values the cycle after.
- With `FPADD_ARB_STATS_EN` defined: 70000 transfers. Required: `op_count`=0xFFFF and it holds there.
